// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard sequencer: forwarding selects, FSM states, stall lengths.
package hazard_pkg;

  localparam logic [2:0] FWD_REG = 3'd0;
  localparam logic [2:0] FWD_WB  = 3'd1;
  localparam logic [2:0] FWD_MEM = 3'd2;

  localparam logic [1:0] STALL_NONE  = 2'd0;
  localparam logic [1:0] STALL_SHORT = 2'd1;
  localparam logic [1:0] STALL_LONG  = 2'd2;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_e;

  // $0 is hardwired, so a write to it never creates a dependency.
  function automatic logic reg_match(input logic we, input logic [4:0] dst, input logic [4:0] src);
    return we && (dst != 5'd0) && (dst == src);
  endfunction

endpackage

// File: rtl/hazard_ctrl_forward_unit.sv
// ALU operand forwarding select for both EX sources; purely combinational, zero latency.
module forward_unit
  import hazard_pkg::*;
(
  input  logic [4:0] ex_rs,
  input  logic [4:0] ex_rt,
  input  logic [4:0] mem_write_reg,
  input  logic       mem_reg_write,
  input  logic [4:0] wb_write_reg,
  input  logic       wb_reg_write,
  output logic [2:0] forward_a,
  output logic [2:0] forward_b
);

  // MEM holds the younger result, so it wins over WB.
  always_comb begin
    forward_a = FWD_REG;
    forward_b = FWD_REG;
    if (reg_match(mem_reg_write, mem_write_reg, ex_rs))     forward_a = FWD_MEM;
    else if (reg_match(wb_reg_write, wb_write_reg, ex_rs))  forward_a = FWD_WB;
    if (reg_match(mem_reg_write, mem_write_reg, ex_rt))     forward_b = FWD_MEM;
    else if (reg_match(wb_reg_write, wb_write_reg, ex_rt))  forward_b = FWD_WB;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/control-flow sequencer: Mealy stall and flush outputs, counted multi-cycle stalls.
// Optional HAZARD_PERF_CNT_EN adds free-running stall and flush event counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int STALL_CW = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ID_INS,
  input  logic        id_branch,
  input  logic        id_jump,
  input  logic        id_uses_rt,
  input  logic        regs_equal,
  input  logic [4:0]  EX_rs,
  input  logic [4:0]  EX_rt,
  input  logic [4:0]  EX_writeReg,
  input  logic        EX_regWrite,
  input  logic        EX_memRead,
  input  logic [4:0]  MEM_writeReg,
  input  logic        MEM_regWrite,
  input  logic        MEM_memRead,
  input  logic [4:0]  WB_writeReg,
  input  logic        WB_regWrite,
  output logic        pcWrite,
  output logic        ifidWrite,
  output logic        stall_needed,
  output logic        ifidFlush,
  output logic        pcSrc,
  output logic        jORb,
  output logic [2:0]  forwardA,
  output logic [2:0]  forwardB
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
`endif
);

  logic [4:0] id_rs, id_rt;
  logic       unused_ins;
  assign id_rs      = ID_INS[25:21];
  assign id_rt      = ID_INS[20:16];
  assign unused_ins = ^{ID_INS[31:26], ID_INS[15:0]};

  logic ex_match, mem_match;
  assign ex_match  = reg_match(EX_regWrite, EX_writeReg, id_rs) ||
                     (id_uses_rt && reg_match(EX_regWrite, EX_writeReg, id_rt));
  assign mem_match = reg_match(MEM_regWrite, MEM_writeReg, id_rs) ||
                     (id_uses_rt && reg_match(MEM_regWrite, MEM_writeReg, id_rt));

  logic [1:0] stall_len;
  always_comb begin
    stall_len = STALL_NONE;
    if (id_branch && EX_memRead && ex_match)
      stall_len = STALL_LONG;
    else if ((EX_memRead && ex_match) ||
             (id_branch && !EX_memRead && ex_match) ||
             (id_branch && MEM_memRead && mem_match))
      stall_len = STALL_SHORT;
  end

  state_e              state_q, state_d;
  logic [STALL_CW-1:0] cnt_q, cnt_d;
  logic                stall;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    case (state_q)
      RUN: begin
        if (stall_len != STALL_NONE) begin
          stall = 1'b1;
          if (stall_len == STALL_LONG) begin
            state_d = STALL;
            cnt_d   = STALL_CW'(STALL_LONG - STALL_SHORT);
          end
        end
      end
      STALL: begin
        stall = 1'b1;
        cnt_d = cnt_q - STALL_CW'(1);
        if (cnt_d == '0) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A stalled branch must not redirect; it re-resolves once the operand is ready.
  always_comb begin
    pcWrite      = !stall;
    ifidWrite    = !stall;
    stall_needed = stall;
    ifidFlush    = 1'b0;
    pcSrc        = 1'b1;
    jORb         = 1'b1;
    if (!stall) begin
      if (id_jump) begin
        pcSrc     = 1'b0;
        jORb      = 1'b0;
        ifidFlush = 1'b1;
      end else if (id_branch && regs_equal) begin
        pcSrc     = 1'b0;
        ifidFlush = 1'b1;
      end
    end
  end

  forward_unit u_fwd (
    .ex_rs         (EX_rs),
    .ex_rt         (EX_rt),
    .mem_write_reg (MEM_writeReg),
    .mem_reg_write (MEM_regWrite),
    .wb_write_reg  (WB_writeReg),
    .wb_reg_write  (WB_regWrite),
    .forward_a     (forwardA),
    .forward_b     (forwardB)
  );

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_count_q, flush_count_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q + {31'd0, stall_needed};
    flush_count_d  = flush_count_q + {31'd0, ifidFlush};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`else
  // No event counters in this build.
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; build with +define+HAZARD_PERF_CNT_EN to cover the counters.
module tb_hazard_ctrl;
  import hazard_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ID_INS;
  logic        id_branch, id_jump, id_uses_rt, regs_equal;
  logic [4:0]  EX_rs, EX_rt, EX_writeReg, MEM_writeReg, WB_writeReg;
  logic        EX_regWrite, EX_memRead, MEM_regWrite, MEM_memRead, WB_regWrite;
  logic        pcWrite, ifidWrite, stall_needed, ifidFlush, pcSrc, jORb;
  logic [2:0]  forwardA, forwardB;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_count;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.STALL_CW(2)) dut (
    .clk(clk), .rst(rst), .ID_INS(ID_INS),
    .id_branch(id_branch), .id_jump(id_jump), .id_uses_rt(id_uses_rt), .regs_equal(regs_equal),
    .EX_rs(EX_rs), .EX_rt(EX_rt), .EX_writeReg(EX_writeReg),
    .EX_regWrite(EX_regWrite), .EX_memRead(EX_memRead),
    .MEM_writeReg(MEM_writeReg), .MEM_regWrite(MEM_regWrite), .MEM_memRead(MEM_memRead),
    .WB_writeReg(WB_writeReg), .WB_regWrite(WB_regWrite),
    .pcWrite(pcWrite), .ifidWrite(ifidWrite), .stall_needed(stall_needed),
    .ifidFlush(ifidFlush), .pcSrc(pcSrc), .jORb(jORb),
    .forwardA(forwardA), .forwardB(forwardB)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
  );

  // add $3,$2,$4 and beq $5,$0
  localparam logic [31:0] INS_ADD = {6'd0, 5'd2, 5'd4, 5'd3, 11'd0};
  localparam logic [31:0] INS_BEQ = {6'd4, 5'd5, 5'd0, 16'd0};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ID_INS = 32'd0; id_branch = 0; id_jump = 0; id_uses_rt = 0; regs_equal = 0;
    EX_rs = 0; EX_rt = 0; EX_writeReg = 0; EX_regWrite = 0; EX_memRead = 0;
    MEM_writeReg = 0; MEM_regWrite = 0; MEM_memRead = 0; WB_writeReg = 0; WB_regWrite = 0;
  endtask

  task automatic set_ex_load(input logic [4:0] r);
    EX_writeReg = r; EX_regWrite = 1; EX_memRead = 1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    tick();
    tick();
    #1;
    tests++; if ({pcWrite, ifidWrite, stall_needed, ifidFlush, pcSrc, jORb} !== 6'b110011) begin
      fails++; $display("FAIL reset_ctrl got %b exp 110011", {pcWrite, ifidWrite, stall_needed, ifidFlush, pcSrc, jORb}); end
    tests++; if ({forwardA, forwardB} !== 6'd0) begin
      fails++; $display("FAIL reset_fwd got %0d/%0d exp 0/0", forwardA, forwardB); end
    rst = 0;
    tick();
    tests++; if (dut.cnt_q !== 2'd0 || dut.state_q !== RUN) begin
      fails++; $display("FAIL reset_state got cnt=%0d st=%0d exp 0/0", dut.cnt_q, dut.state_q); end
`ifdef HAZARD_PERF_CNT_EN
    tests++; if (stall_cycles !== 32'd0 || flush_count !== 32'd0) begin
      fails++; $display("FAIL reset_perf got %0d/%0d exp 0/0", stall_cycles, flush_count); end
`endif
  endtask

  task automatic test_load_use();
    clear_inputs();
    ID_INS = INS_ADD; id_uses_rt = 1; set_ex_load(5'd2);
    #1;
    tests++; if ({stall_needed, pcWrite, ifidWrite} !== 3'b100) begin
      fails++; $display("FAIL lu_stall got %b exp 100", {stall_needed, pcWrite, ifidWrite}); end
    tick();
    EX_writeReg = 0; EX_regWrite = 0; EX_memRead = 0;
    MEM_writeReg = 5'd2; MEM_regWrite = 1; MEM_memRead = 1;
    #1;
    tests++; if ({stall_needed, pcWrite, ifidWrite} !== 3'b011) begin
      fails++; $display("FAIL lu_release got %b exp 011", {stall_needed, pcWrite, ifidWrite}); end
    tick();
    // add moves to EX, lw result now in WB
    clear_inputs();
    EX_rs = 5'd2; EX_rt = 5'd4; WB_writeReg = 5'd2; WB_regWrite = 1;
    #1;
    tests++; if (forwardA !== FWD_WB || forwardB !== FWD_REG) begin
      fails++; $display("FAIL lu_fwd got %0d/%0d exp 1/0", forwardA, forwardB); end
    tick();
  endtask

  task automatic test_rt_gating();
    clear_inputs();
    ID_INS = INS_ADD; id_uses_rt = 0; set_ex_load(5'd4);
    #1;
    tests++; if (stall_needed !== 1'b0) begin
      fails++; $display("FAIL rt_unused got %b exp 0", stall_needed); end
    id_uses_rt = 1;
    #1;
    tests++; if (stall_needed !== 1'b1) begin
      fails++; $display("FAIL rt_used got %b exp 1", stall_needed); end
    tick();
    clear_inputs();
    ID_INS = {6'd0, 5'd0, 5'd0, 5'd3, 11'd0}; id_uses_rt = 1; set_ex_load(5'd0);
    #1;
    tests++; if (stall_needed !== 1'b0) begin
      fails++; $display("FAIL load_r0 got %b exp 0", stall_needed); end
    tick();
  endtask

  task automatic test_branch_load();
    clear_inputs();
    ID_INS = INS_BEQ; id_branch = 1; id_uses_rt = 1; regs_equal = 1; set_ex_load(5'd5);
    #1;
    tests++; if ({stall_needed, pcWrite, ifidFlush, pcSrc} !== 4'b1001) begin
      fails++; $display("FAIL bl_c1 got %b exp 1001", {stall_needed, pcWrite, ifidFlush, pcSrc}); end
    tick();
    EX_writeReg = 0; EX_regWrite = 0; EX_memRead = 0;
    MEM_writeReg = 5'd5; MEM_regWrite = 1; MEM_memRead = 1;
    #1;
    tests++; if ({stall_needed, pcWrite, ifidFlush, pcSrc} !== 4'b1001 || dut.cnt_q !== 2'd1) begin
      fails++; $display("FAIL bl_c2 got %b cnt=%0d exp 1001 cnt=1", {stall_needed, pcWrite, ifidFlush, pcSrc}, dut.cnt_q); end
    tick();
    MEM_writeReg = 0; MEM_regWrite = 0; MEM_memRead = 0;
    WB_writeReg = 5'd5; WB_regWrite = 1;
    #1;
    tests++; if ({stall_needed, ifidFlush, pcSrc, jORb} !== 4'b0101) begin
      fails++; $display("FAIL bl_c3 got %b exp 0101", {stall_needed, ifidFlush, pcSrc, jORb}); end
    tick();
  endtask

  task automatic test_branch_short();
    // ALU producer in EX: one stall, then resolved
    clear_inputs();
    ID_INS = INS_BEQ; id_branch = 1; id_uses_rt = 1; regs_equal = 1;
    EX_writeReg = 5'd5; EX_regWrite = 1;
    #1;
    tests++; if (stall_needed !== 1'b1 || ifidFlush !== 1'b0) begin
      fails++; $display("FAIL ba_c1 got %b%b exp 10", stall_needed, ifidFlush); end
    tick();
    EX_writeReg = 0; EX_regWrite = 0; MEM_writeReg = 5'd5; MEM_regWrite = 1;
    #1;
    tests++; if (stall_needed !== 1'b0 || ifidFlush !== 1'b1) begin
      fails++; $display("FAIL ba_c2 got %b%b exp 01", stall_needed, ifidFlush); end
    tick();
    // load in MEM: one stall
    MEM_memRead = 1;
    #1;
    tests++; if (stall_needed !== 1'b1 || dut.state_d !== RUN) begin
      fails++; $display("FAIL bm_c1 got %b st_d=%0d exp 1/0", stall_needed, dut.state_d); end
    tick();
    MEM_writeReg = 0; MEM_regWrite = 0; MEM_memRead = 0; WB_writeReg = 5'd5; WB_regWrite = 1;
    regs_equal = 0;
    #1;
    tests++; if ({stall_needed, ifidFlush, pcSrc} !== 3'b001) begin
      fails++; $display("FAIL bm_nt got %b exp 001", {stall_needed, ifidFlush, pcSrc}); end
    tick();
  endtask

  task automatic test_jump();
    clear_inputs();
    id_jump = 1;
    #1;
    tests++; if ({ifidFlush, pcSrc, jORb, stall_needed} !== 4'b1000) begin
      fails++; $display("FAIL jump got %b exp 1000", {ifidFlush, pcSrc, jORb, stall_needed}); end
    tick();
    id_jump = 0;
    #1;
    tests++; if ({ifidFlush, pcSrc, jORb} !== 3'b011) begin
      fails++; $display("FAIL jump_after got %b exp 011", {ifidFlush, pcSrc, jORb}); end
  endtask

  task automatic test_forwarding();
    clear_inputs();
    EX_rs = 5'd7; EX_rt = 5'd7;
    MEM_writeReg = 5'd7; MEM_regWrite = 1; WB_writeReg = 5'd7; WB_regWrite = 1;
    #1;
    tests++; if (forwardA !== FWD_MEM || forwardB !== FWD_MEM) begin
      fails++; $display("FAIL fwd_prio got %0d/%0d exp 2/2", forwardA, forwardB); end
    MEM_regWrite = 0;
    #1;
    tests++; if (forwardA !== FWD_WB || forwardB !== FWD_WB) begin
      fails++; $display("FAIL fwd_wb got %0d/%0d exp 1/1", forwardA, forwardB); end
    EX_rs = 5'd0; EX_rt = 5'd9; MEM_writeReg = 5'd0; MEM_regWrite = 1; WB_writeReg = 5'd0;
    #1;
    tests++; if (forwardA !== FWD_REG || forwardB !== FWD_REG) begin
      fails++; $display("FAIL fwd_r0 got %0d/%0d exp 0/0", forwardA, forwardB); end
    EX_rt = 5'd9; MEM_writeReg = 5'd9;
    #1;
    tests++; if (forwardA !== FWD_REG || forwardB !== FWD_MEM) begin
      fails++; $display("FAIL fwd_b got %0d/%0d exp 0/2", forwardA, forwardB); end
  endtask

  task automatic test_reset_mid_stall();
    clear_inputs();
    ID_INS = INS_BEQ; id_branch = 1; id_uses_rt = 1; regs_equal = 1; set_ex_load(5'd5);
    tick();
    clear_inputs();
    #1;
    tests++; if (dut.state_q !== STALL || stall_needed !== 1'b1) begin
      fails++; $display("FAIL ms_enter got st=%0d stall=%b exp 1/1", dut.state_q, stall_needed); end
`ifdef HAZARD_PERF_CNT_EN
    tests++; if (stall_cycles === 32'd0) begin
      fails++; $display("FAIL ms_perf_pre got %0d exp nonzero", stall_cycles); end
`endif
    rst = 1;
    tick();
    rst = 0;
    #1;
    tests++; if (stall_needed !== 1'b0 || pcWrite !== 1'b1 || dut.state_q !== RUN) begin
      fails++; $display("FAIL ms_exit got stall=%b pcw=%b st=%0d exp 0/1/0", stall_needed, pcWrite, dut.state_q); end
`ifdef HAZARD_PERF_CNT_EN
    tests++; if (stall_cycles !== 32'd0 || flush_count !== 32'd0) begin
      fails++; $display("FAIL ms_perf got %0d/%0d exp 0/0", stall_cycles, flush_count); end
`endif
    tick();
    tests++; if (stall_needed !== 1'b0) begin
      fails++; $display("FAIL ms_residual got %b exp 0", stall_needed); end
  endtask

`ifdef HAZARD_PERF_CNT_EN
  task automatic test_perf();
    // counters were cleared by the mid-stall reset; 1 stall + 1 flush
    clear_inputs();
    id_jump = 1;
    tick();
    clear_inputs();
    ID_INS = INS_ADD; id_uses_rt = 1; set_ex_load(5'd2);
    tick();
    clear_inputs();
    #1;
    tests++; if (stall_cycles !== 32'd1 || flush_count !== 32'd1) begin
      fails++; $display("FAIL perf got %0d/%0d exp 1/1", stall_cycles, flush_count); end
  endtask
`endif

  initial begin
    test_reset();
    test_load_use();
    test_rt_gating();
    test_branch_load();
    test_branch_short();
    test_jump();
    test_forwarding();
    test_reset_mid_stall();
`ifdef HAZARD_PERF_CNT_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end

endmodule
